// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type, default timing constants and width helper for debounce_bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_REPEAT_DELAY    = 500000;
  localparam int DEF_REPEAT_PERIOD   = 100000;
  localparam int DEF_CNT_W           = 22;

  // Bits needed to hold values 0..v (at least one bit).
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel -- two-flop synchronizer, 4-state debounce FSM with rise/fall pulses,
// and an auto-repeat timer that exists only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_1M,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rep
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  state_t st;
  logic sync0;
  logic sync1;
  logic [CNT_W-1:0] cnt;

  // Bring the raw pin into the clk_1M domain before anything looks at it.
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= din;
      sync1 <= sync0;
    end
  end

  // Debounce FSM: a change must hold for DEBOUNCE_CYCLES+1 samples; any revert aborts silently.
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      st    <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (st)
        STABLE_LO, STABLE_HI: begin
          if (sync1 != level) begin
            st  <= level ? WAIT_LO : WAIT_HI;
            cnt <= LOAD;
          end
        end
        WAIT_HI, WAIT_LO: begin
          if (sync1 == level) begin
            st <= level ? STABLE_HI : STABLE_LO;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            st    <= sync1 ? STABLE_HI : STABLE_LO;
            level <= sync1;
            rise  <= sync1;
            fall  <= ~sync1;
          end
        end
      endcase
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = width_for((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [RW-1:0] tmr;
  logic armed;
  logic hold_hi;

  // The timer only runs while the channel stays in STABLE_HI; any other state clears it.
  assign hold_hi = (st == STABLE_HI) && (sync1 == level);

  // First pulse REPEAT_DELAY cycles after entering STABLE_HI, then every REPEAT_PERIOD cycles.
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      tmr   <= '0;
      armed <= 1'b0;
      rep   <= 1'b0;
    end else if (!hold_hi) begin
      tmr   <= '0;
      armed <= 1'b0;
      rep   <= 1'b0;
    end else if (tmr == (armed ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
      tmr   <= '0;
      armed <= 1'b1;
      rep   <= 1'b1;
    end else begin
      tmr <= tmr + 1'b1;
      rep <= 1'b0;
    end
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debounce channels with level, rise/fall pulses and
// optional auto-repeat (define DEBOUNCE_AUTOREPEAT_EN; otherwise rep is tied low).
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk_1M,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rep
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be in 1..32");
  end

  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("debounce_bank: CNT_W out of range");
  end

  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cycles
    $error("debounce_bank: DEBOUNCE_CYCLES must be nonzero and fit in CNT_W bits");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_1M(clk_1M),
      .rst   (rst),
      .din   (din[c]),
      .level (level[c]),
      .rise  (rise[c]),
      .fall  (fall[c]),
      .rep   (rep[c])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed + random stimulus against a sample-window reference model of debounce_bank.
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int D  = 10;
  localparam int RD = 30;
  localparam int RP = 8;

  logic          clk_1M = 1'b0;
  logic          rst    = 1'b1;
  logic [CH-1:0] din    = '0;
  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] rep;

  always #5 clk_1M = ~clk_1M;

  debounce_bank #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (22),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_1M(clk_1M),
    .rst   (rst),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .rep   (rep)
  );

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  // Model: per channel, the history of din values sampled at each edge (newest first).
  // The FSM sees a sample two edges late; level flips when its last D+1 visible samples all differ from it.
  bit            samp[CH][$];
  logic [CH-1:0] m_level;
  logic [CH-1:0] m_rise;
  logic [CH-1:0] m_fall;
  logic [CH-1:0] m_rep;
  int            since[CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      samp[c].delete();
      repeat (D + 3) samp[c].push_back(1'b0);
      since[c] = -1;
    end
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_rep   = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit vis;
      bit flip;
      int k;
      samp[c].push_front(din[c]);
      void'(samp[c].pop_back());
      vis  = samp[c][2];
      flip = 1'b1;
      for (int j = 2; j <= D + 2; j++) if (samp[c][j] == m_level[c]) flip = 1'b0;
      k = since[c] + 1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      m_rep[c] = (since[c] >= 0) && vis && (k == RD || (k > RD && (k - RD) % RP == 0));
`else
      m_rep[c] = 1'b0;
`endif
      m_rise[c] = flip && !m_level[c];
      m_fall[c] = flip && m_level[c];
      if (flip) m_level[c] = !m_level[c];
      since[c] = (m_level[c] && vis) ? k : -1;
    end
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (level === m_level) else begin errs++; $error("FAIL %s level got %b want %b", tag, level, m_level); end
    assert (rise === m_rise) else begin errs++; $error("FAIL %s rise got %b want %b", tag, rise, m_rise); end
    assert (fall === m_fall) else begin errs++; $error("FAIL %s fall got %b want %b", tag, fall, m_fall); end
    assert (rep === m_rep) else begin errs++; $error("FAIL %s rep got %b want %b", tag, rep, m_rep); end
  endtask

  task automatic step(input string tag);
    @(posedge clk_1M);
    cyc++;
    if (rst) model_reset();
    else model_edge();
    #1;
    check(tag);
  endtask

  // Step until rise[ch] appears (bounded), then require it exactly lat edges after edge t0.
  task automatic await_rise(input int ch, input int t0, input int lat, input string tag);
    int n;
    n = 0;
    while (rise[ch] !== 1'b1 && n < 40) begin
      step(tag);
      n++;
    end
    assert (rise[ch] === 1'b1 && cyc - t0 == lat) else begin
      errs++;
      $error("FAIL %s rise seen=%b at edge offset %0d want offset %0d", tag, rise[ch], cyc - t0, lat);
    end
  endtask

  initial begin
    int t0;
    int bad;
    int reps;
    int n;
    logic [CH-1:0] seen;

    model_reset();
    rst = 1'b1;
    din = '0;
    repeat (3) step("reset");
    rst = 1'b0;
    repeat (3) step("idle");

    din[0] = 1'b1;
    t0 = cyc + 1;
    await_rise(0, t0, 12, "lat_ch0");
    repeat (5) step("hold_ch0");

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      din[1] = ((i / 4) % 2 == 0);
      step("chatter");
      if (rise[1] | fall[1] | level[1]) bad++;
    end
    din[1] = 1'b0;
    repeat (20) begin
      step("chatter_tail");
      if (rise[1] | fall[1] | level[1]) bad++;
    end
    assert (bad == 0) else begin errs++; $error("FAIL chatter_quiet events got %0d want 0", bad); end

    din[2] = 1'b1;
    repeat (9) step("short_hi");
    din[2] = 1'b0;
    step("glitch_lo");
    din[2] = 1'b1;
    t0 = cyc + 1;
    await_rise(2, t0, 12, "restart_ch2");

    din = '0;
    repeat (15) step("settle");
    din = 4'b1111;
    n = 0;
    seen = '0;
    while (seen == '0 && n < 40) begin step("all_rise"); seen = rise; n++; end
    assert (seen === 4'b1111) else begin errs++; $error("FAIL all_rise got %b want %b", seen, 4'b1111); end
    repeat (5) step("all_hold");
    din = '0;
    n = 0;
    seen = '0;
    while (seen == '0 && n < 40) begin step("all_fall"); seen = fall; n++; end
    assert (seen === 4'b1111) else begin errs++; $error("FAIL all_fall got %b want %b", seen, 4'b1111); end
    repeat (15) step("settle2");

    din = 4'b1111;
    repeat (7) step("wait_hi");
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst");
    repeat (2) step("in_rst");
    rst = 1'b0;
    t0 = cyc + 1;
    await_rise(0, t0, 12, "rst_requal");

    reps = 0;
    repeat (70) begin step("repeat_hold"); if (rep[0]) reps++; end
`ifdef DEBOUNCE_AUTOREPEAT_EN
    assert (reps == 6) else begin errs++; $error("FAIL repeat_count got %0d want %0d", reps, 6); end
`else
    assert (reps == 0) else begin errs++; $error("FAIL repeat_count got %0d want %0d", reps, 0); end
`endif
    din = '0;
    reps = 0;
    repeat (40) begin step("repeat_release"); if (rep[0]) reps++; end
    assert (reps == 0) else begin errs++; $error("FAIL repeat_after_release got %0d want 0", reps); end

    repeat (60) begin
      din = CH'($urandom);
      repeat ($urandom_range(1, 16)) step("random");
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("random_rst");
        step("random_rst");
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
